// File: rtl/karatsuba_seq_10.sv
// Sequential 10x10 carry-less (GF(2) polynomial) multiplier.
// A single 5x5 carry-less Karatsuba core is time-multiplexed over three cycles
// (low, high, middle partial products), then the 19-bit product is held in DONE
// until the consumer takes it.

// 5x5 carry-less Karatsuba multiplier, purely combinational, 9-bit result.
// Operands split as 3 low bits / 2 high bits; 3x3 carry-less products are built
// by shift-and-XOR.
module clmul_kara_5x5 (
    input  logic [4:0] a,
    input  logic [4:0] b,
    output logic [8:0] p
);

    // 3x3 carry-less product, degree <= 4.
    function automatic logic [4:0] clmul3(input logic [2:0] x, input logic [2:0] y);
        logic [4:0] acc;
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            if (y[i]) begin
                acc = acc ^ ({2'b00, x} << i);
            end
        end
        return acc;
    endfunction

    logic [2:0] a_lo, b_lo;
    logic [2:0] a_hi, b_hi;
    logic [2:0] a_sum, b_sum;
    logic [4:0] q0, q1, q2;
    logic [4:0] q_mid;

    assign a_lo  = a[2:0];
    assign b_lo  = b[2:0];
    assign a_hi  = {1'b0, a[4:3]};
    assign b_hi  = {1'b0, b[4:3]};
    assign a_sum = a_lo ^ a_hi;
    assign b_sum = b_lo ^ b_hi;

    // Three sub-products and recombination; every addition is an XOR.
    always_comb begin
        q0    = clmul3(a_lo, b_lo);
        q2    = clmul3(a_hi, b_hi);
        q1    = clmul3(a_sum, b_sum);
        q_mid = q1 ^ q0 ^ q2;
        p     = ({4'b0000, q2} << 6) ^ ({4'b0000, q_mid} << 3) ^ {4'b0000, q0};
    end

endmodule

// Top level: operand capture, FSM, partial-product registers and result.
module karatsuba_seq_10 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  a,
    input  logic [9:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [18:0] c
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StMulLo  = 3'd1;
    localparam logic [2:0] StMulHi  = 3'd2;
    localparam logic [2:0] StMulMid = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [4:0]  a_l_q, a_h_q, b_l_q, b_h_q;
    logic [8:0]  p0_q, p2_q;
    logic [18:0] c_q, c_d;

    logic [4:0]  mul_a, mul_b;
    logic [8:0]  mul_p;
    logic [8:0]  mid;
    logic        accept;

    // Handshake outputs depend on state only.
    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign c         = c_q;
    assign accept    = in_ready && in_valid;

    clmul_kara_5x5 u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    // Steer the shared multiplier according to the current phase.
    always_comb begin
        mul_a = a_l_q;
        mul_b = b_l_q;
        case (state_q)
            StMulHi: begin
                mul_a = a_h_q;
                mul_b = b_h_q;
            end
            StMulMid: begin
                mul_a = a_h_q ^ a_l_q;
                mul_b = b_h_q ^ b_l_q;
            end
            default: begin
                mul_a = a_l_q;
                mul_b = b_l_q;
            end
        endcase
    end

    // Final recombination uses the live middle product during MUL_MID.
    always_comb begin
        mid = mul_p ^ p0_q ^ p2_q;
        c_d = ({10'd0, p2_q} << 10) ^ ({10'd0, mid} << 5) ^ {10'd0, p0_q};
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (in_valid) state_d = StMulLo;
            StMulLo:  state_d = StMulHi;
            StMulHi:  state_d = StMulMid;
            StMulMid: state_d = StDone;
            StDone:   if (out_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State, operand capture, partial products and result; reset wins over handshakes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_l_q   <= '0;
            a_h_q   <= '0;
            b_l_q   <= '0;
            b_h_q   <= '0;
            p0_q    <= '0;
            p2_q    <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_l_q <= a[4:0];
                a_h_q <= a[9:5];
                b_l_q <= b[4:0];
                b_h_q <= b[9:5];
            end
            if (state_q == StMulLo) begin
                p0_q <= mul_p;
            end
            if (state_q == StMulHi) begin
                p2_q <= mul_p;
            end
            if (state_q == StMulMid) begin
                c_q <= c_d;
            end
        end
    end

endmodule

// File: tb/tb_karatsuba_seq_10.sv
// Bench for karatsuba_seq_10: directed corner cases, backpressure, mid-operation
// reset and a long back-to-back random run against a carry-less reference model.
module tb_karatsuba_seq_10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  a, b;
    logic        out_valid;
    logic        out_ready;
    logic [18:0] c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    karatsuba_seq_10 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    // Reference: polynomial product over GF(2), bit by bit.
    function automatic logic [18:0] clmul_ref(input logic [9:0] x, input logic [9:0] y);
        logic [18:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 10; j++) begin
                r[i+j] = r[i+j] ^ (x[i] & y[j]);
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation from IDLE (called at a negedge), check latency and result,
    // then return at the negedge where the block is back in IDLE.
    task automatic do_op(input string tag, input logic [9:0] x, input logic [9:0] y);
        int lat;
        logic [18:0] exp_c;
        exp_c = clmul_ref(x, y);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 10'($urandom); b = 10'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_c"}, 32'(c), 32'(exp_c));
        @(negedge clk);
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
        check({tag, "_c_hold"}, 32'(c), 32'(exp_c));
    endtask

    initial begin
        logic [9:0]  x, y;
        logic [18:0] q[$];
        logic [18:0] exp_c;
        int          cyc, last_acc, done_ops, n;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_c", 32'(c), 32'd0);

        do_op("sq21", 10'h021, 10'h021);
        do_op("ones", 10'h3FF, 10'h001);
        do_op("top", 10'h200, 10'h200);
        check("top_const", 32'(clmul_ref(10'h200, 10'h200)), 32'h40000);

        // Backpressure: product held with out_ready low while inputs churn.
        a = 10'h021; b = 10'h021; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            a = 10'($urandom); b = 10'($urandom);
            n++;
        end while (!out_valid && n < 20);
        check("bp_reach_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            a = 10'($urandom); b = 10'($urandom);
            @(negedge clk);
            check("bp_c", 32'(c), 32'h00401);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        a = 10'($urandom); b = 10'($urandom);
        @(negedge clk);
        check("bp_release_idle", 32'(in_ready), 32'd1);
        x = 10'($urandom); y = 10'($urandom);
        in_valid = 1'b0;
        do_op("bp_next", x, y);

        // Reset while in MUL_HI abandons the operation.
        a = 10'h155; b = 10'h2AA; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_c", 32'(c), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("mrst_no_result", 32'(n), 32'd0);

        // Back-to-back random traffic with both handshakes held high.
        in_valid = 1'b1; out_ready = 1'b1;
        cyc = 0; last_acc = -1; done_ops = 0;
        while (done_ops < 1000 && cyc < 6000) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("b2b_unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    exp_c = q.pop_front();
                    check("b2b_c", 32'(c), 32'(exp_c));
                    done_ops++;
                end
            end
            a = 10'($urandom); b = 10'($urandom);
            if (in_ready) begin
                if (last_acc >= 0) check("b2b_interval", 32'(cyc - last_acc), 32'd5);
                q.push_back(clmul_ref(a, b));
                last_acc = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        check("b2b_count", 32'(done_ops), 32'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
